winograd_filter_xform_ctrl: RTL and testbench

//   Sequencer for the 3x3 -> 4x4 Winograd filter transform unit. Accepts a burst of
//   raw 3x3 filters over a valid/ready stream and drives them one at a time into the

---
 rtl/winograd_filter_xform_ctrl.sv | 174 +++++++++++++++++
 tb/tb_winograd_filter_xform_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_filter_xform_ctrl.sv
// ---------------------------------------------------------------------------
// winograd_filter_xform_ctrl
//
// Sequences a burst of raw 3x3 filters from the weight-fetch stream through
// the Winograd filter transform unit. For each filter it registers the taps
// toward the transform unit and waits out the unit's fixed latency. It then
// writes the 4x4 transformed result into the weight buffer at consecutive
// addresses starting from 0.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start, cfg_count   burst request and filter count (1..2**ADDR_W), IDLE only
//   f_valid/f_ready    raw-filter stream handshake, f_data = 9 x 8-bit taps
//   xf_filter          registered filter taps driven to the transform unit
//   xf_result          transform unit output, 16 x 8-bit
//   wb_we/addr/data    weight-buffer write port
//   busy, done, err    status: not idle, burst-complete pulse, bad-count pulse
//
// State | meaning
//   IDLE   | waiting for start
//   ACCEPT | f_ready high, waiting for the next raw filter
//   WAIT   | filter in flight through the transform unit
//   WRITE  | transformed filter written to the buffer
//   DONE   | one-cycle burst-complete pulse
// ---------------------------------------------------------------------------
module winograd_filter_xform_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int XFORM_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W:0]   cfg_count,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [71:0]       f_data,
    output logic [71:0]       xf_filter,
    input  logic [127:0]      xf_result,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [127:0]      wb_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int                LAT_W     = (XFORM_LAT > 1) ? $clog2(XFORM_LAT + 1) : 1;
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(XFORM_LAT);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t             state_q, state_d;
    logic [ADDR_W:0]    idx_q, idx_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [71:0]        xf_filter_q, xf_filter_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic               f_ready_q, f_ready_d;
    logic               wb_we_q, wb_we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic cfg_legal;
    logic f_handshake;
    logic last_filter;

    assign cfg_legal   = (cfg_count != '0) && (cfg_count <= MAX_COUNT);
    assign f_handshake = (state_q == S_ACCEPT) && f_valid && f_ready_q;
    // idx is one bit wider than the address so a full 2**ADDR_W burst can
    // still compare against count-1 without wrapping.
    assign last_filter = (idx_q == (count_q - CNT_ONE));

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            lat_cnt_q   <= '0;
            xf_filter_q <= '0;
            wb_addr_q   <= '0;
            f_ready_q   <= 1'b0;
            wb_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            lat_cnt_q   <= lat_cnt_d;
            xf_filter_q <= xf_filter_d;
            wb_addr_q   <= wb_addr_d;
            f_ready_q   <= f_ready_d;
            wb_we_q     <= wb_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && cfg_legal) state_d = S_ACCEPT;
            S_ACCEPT: if (f_handshake) state_d = S_WAIT;
            S_WAIT:   if (lat_cnt_q <= LAT_ONE) state_d = S_WRITE;
            S_WRITE:  state_d = last_filter ? S_DONE : S_ACCEPT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath. Status outputs are decoded from the next state so
    // that the registered copies line up with the state they describe.
    always_comb begin
        idx_d       = idx_q;
        count_d     = count_q;
        lat_cnt_d   = lat_cnt_q;
        xf_filter_d = xf_filter_q;
        wb_addr_d   = wb_addr_q;
        err_d       = (state_q == S_IDLE) && start && !cfg_legal;

        case (state_q)
            S_IDLE: begin
                if (start && cfg_legal) begin
                    count_d = cfg_count;
                    idx_d   = '0;
                end
            end
            S_ACCEPT: begin
                if (f_handshake) begin
                    xf_filter_d = f_data;
                    lat_cnt_d   = LAT_INIT;
                end
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_ONE;
                if (state_d == S_WRITE) wb_addr_d = idx_q[ADDR_W-1:0];
            end
            S_WRITE: begin
                idx_d = idx_q + CNT_ONE;
            end
            default: ;
        endcase

        f_ready_d = (state_d == S_ACCEPT);
        wb_we_d   = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    assign f_ready   = f_ready_q;
    assign xf_filter = xf_filter_q;
    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    // The transform unit's result is already aligned with the WRITE cycle.
    assign wb_data   = xf_result;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_winograd_filter_xform_ctrl.sv
module tb_winograd_filter_xform_ctrl;

    localparam int ADDR_W    = 4;
    localparam int XFORM_LAT = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   cfg_count = '0;
    logic              f_valid = 1'b0;
    logic              f_ready;
    logic [71:0]       f_data = '0;
    logic [71:0]       xf_filter;
    logic [127:0]      xf_result;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [127:0]      wb_data;
    logic              busy;
    logic              done;
    logic              err;

    winograd_filter_xform_ctrl #(.ADDR_W(ADDR_W), .XFORM_LAT(XFORM_LAT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_count(cfg_count),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .xf_filter(xf_filter), .xf_result(xf_result),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden transform U = G g G^T with G scaled by 2 to stay integer, then /4.
    function automatic logic [127:0] xform(input logic [71:0] f);
        int g [3][3];
        int t [4][3];
        int u [4];
        int v;
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 3; c++)
                g[i][c] = int'($signed(f[8*(i*3+c) +: 8]));
        for (int c = 0; c < 3; c++) begin
            t[0][c] = 2 * g[0][c];
            t[1][c] = g[0][c] + g[1][c] + g[2][c];
            t[2][c] = g[0][c] - g[1][c] + g[2][c];
            t[3][c] = 2 * g[2][c];
        end
        for (int i = 0; i < 4; i++) begin
            u[0] = 2 * t[i][0];
            u[1] = t[i][0] + t[i][1] + t[i][2];
            u[2] = t[i][0] - t[i][1] + t[i][2];
            u[3] = 2 * t[i][2];
            for (int j = 0; j < 4; j++) begin
                v = u[j] >>> 2;
                r[8*(i*4+j) +: 8] = v[7:0];
            end
        end
        return r;
    endfunction

    // Transform unit model: two-stage pipeline behind xf_filter.
    logic [127:0] pipe1 = '0, pipe2 = '0;
    always @(posedge clk) begin
        pipe1 <= xform(xf_filter);
        pipe2 <= pipe1;
    end
    assign xf_result = pipe2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor state
    logic [71:0]       exp_q[$];
    int                hs_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [127:0]      wr_data_q[$];
    int last_hs = -100;
    int last_wr = -100;
    int done_cyc = -100;
    int done_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int viol = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (f_ready && cyc >= last_hs && cyc <= last_hs + XFORM_LAT) viol++;
            if (f_ready && !busy) viol++;
            if (wb_we && f_ready) viol++;
            if (done && err) viol++;
            if (f_valid && f_ready) begin
                exp_q.push_back(f_data);
                hs_q.push_back(cyc + 1);
                last_hs = cyc + 1;
            end
            if (wb_we) begin
                wr_addr_q.push_back(wb_addr);
                wr_data_q.push_back(wb_data);
                last_wr = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d with no filter pending", wb_addr);
                end else begin
                    logic [71:0] e;
                    int h;
                    e = exp_q.pop_front();
                    h = hs_q.pop_front();
                    chk("wb_data", wb_data, xform(e));
                    chk("write_latency", 128'(cyc - h), 128'(XFORM_LAT));
                end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic clear_mon();
        exp_q.delete(); hs_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        last_hs = -100; last_wr = -100; done_cyc = -100;
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; viol = 0;
    endtask

    function automatic logic [71:0] pattern(input int k);
        logic [71:0] base;
        base = 72'h040404060606080808;
        return base + 72'(k) * 72'h010203040506070809;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic feed_filter(input int k, input int gap);
        bit ok;
        repeat (gap) begin @(posedge clk); #1; end
        f_valid = 1'b1;
        f_data  = pattern(k);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (f_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        f_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL hs_timeout: filter %0d f_ready never asserted", k);
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W:0] cnt);
        start = 1'b1; cfg_count = cnt;
        @(posedge clk); #1;
        start = 1'b0; cfg_count = '0;
    endtask

    typedef struct {
        logic [ADDR_W:0] cnt;
        int              gap;
        bit              mid_start;
        bit              exp_err;
        int              exp_wr;
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        int n;
        bit seen;
        clear_mon();
        pulse_start(v.cnt);
        if (v.exp_err) begin
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d err_pulses", id), 128'(err_cnt), 128'(1));
            chk($sformatf("v%0d err_writes", id), 128'(wr_addr_q.size()), 128'(0));
            chk($sformatf("v%0d err_busy", id), 128'(busy_cnt), 128'(0));
            chk($sformatf("v%0d err_done", id), 128'(done_cnt), 128'(0));
        end else begin
            if (v.mid_start) pulse_start(5'd3);
            for (int k = 0; k < v.exp_wr; k++) feed_filter(k, k % (v.gap + 1));
            seen = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (done_cnt > 0) begin seen = 1'b1; break; end
            end
            repeat (3) @(negedge clk);
            if (!seen) $display("FAIL v%0d done_timeout: done never pulsed", id);
            chk($sformatf("v%0d n_writes", id), 128'(wr_addr_q.size()), 128'(v.exp_wr));
            n = (wr_addr_q.size() < v.exp_wr) ? wr_addr_q.size() : v.exp_wr;
            for (int i = 0; i < n; i++)
                chk($sformatf("v%0d wr_addr[%0d]", id, i), 128'(wr_addr_q[i]), 128'(i));
            chk($sformatf("v%0d done_cnt", id), 128'(done_cnt), 128'(1));
            chk($sformatf("v%0d done_after_write", id), 128'(done_cyc), 128'(last_wr + 1));
            chk($sformatf("v%0d err_cnt", id), 128'(err_cnt), 128'(0));
            chk($sformatf("v%0d protocol", id), 128'(viol), 128'(0));
            chk($sformatf("v%0d idle_after", id), 128'({busy, f_ready}), 128'(0));
            if (id == 0 && wr_data_q.size() > 0)
                chk("single_golden", wr_data_q[0], 128'h04020604_03010403_09040d09_08040c08);
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{cnt: 5'd1,  gap: 0, mid_start: 1'b0, exp_err: 1'b0, exp_wr: 1};
        vecs[1] = '{cnt: 5'd4,  gap: 3, mid_start: 1'b0, exp_err: 1'b0, exp_wr: 4};
        vecs[2] = '{cnt: 5'd0,  gap: 0, mid_start: 1'b0, exp_err: 1'b1, exp_wr: 0};
        vecs[3] = '{cnt: 5'd17, gap: 0, mid_start: 1'b0, exp_err: 1'b1, exp_wr: 0};
        vecs[4] = '{cnt: 5'd2,  gap: 1, mid_start: 1'b1, exp_err: 1'b0, exp_wr: 2};
        vecs[5] = '{cnt: 5'd16, gap: 0, mid_start: 1'b0, exp_err: 1'b0, exp_wr: 16};
        vecs[6] = '{cnt: 5'd3,  gap: 2, mid_start: 1'b0, exp_err: 1'b0, exp_wr: 3};

        // Reset held for 4 cycles
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outputs",
            {xf_filter, 4'(wb_addr), f_ready, wb_we, busy, done, err}, 128'(0));
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 128'({busy, f_ready}), 128'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset during WAIT of the second filter
        clear_mon();
        pulse_start(5'd3);
        feed_filter(0, 0);
        feed_filter(1, 0);
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_writes_before", 128'(wr_addr_q.size()), 128'(1));
        chk("abort_outputs",
            {xf_filter, 4'(wb_addr), f_ready, wb_we, busy, done, err}, 128'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        run_vec('{cnt: 5'd2, gap: 0, mid_start: 1'b0, exp_err: 1'b0, exp_wr: 2}, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
